exp_arbiter: RTL
================

EXP_ARBITER -- requirements
Module: exp_arbiter

Interface
REQ-001 Parameter VEC_BASE, default 32'h0000_0800, SHALL be the exception vector base address.
REQ-002 Parameter VEC_STRIDE, default 32'h0000_0010, SHALL be the address distance between per-cause vectors.
REQ-003 Port clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 Port rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-005 Port exp_src  input  3  SHALL carry raw exception sources; bit 0 is expSrc0, bit 2 is expSrc2.
REQ-006 Port mask_we  input  1  SHALL be the write strobe for the mask register.
REQ-007 Port mask_din  input  3  SHALL be the new mask value; 1 = source enabled.
REQ-008 Port exp_ack  input  1  SHALL mean the PC logic took the exception this cycle.
REQ-009 Port eret  input  1  SHALL mean an ERET instruction executes this cycle.
REQ-010 Port has_exp  output  1  SHALL be the exception request to the PC logic.
REQ-011 Port exp_cause  output  2  SHALL be the granted source index 0..2.
REQ-012 Port exp_vector  output  32  SHALL be the target PC for the granted cause.
REQ-013 Port in_service  output  1  SHALL be high while a handler runs.
REQ-014 Port pending  output  3  SHALL expose the pending bits.
REQ-015 Port mask  output  3  SHALL expose the mask register.
REQ-016 Port cnt0, cnt1, cnt2  output  16 each  SHALL be the per-source grant counts.

Function
REQ-017 A rising edge SHALL be detected as exp_src[i]=1 with prev[i]=0; prev is the registered exp_src.
REQ-018 A detected edge SHALL set pending[i] at that clock edge, regardless of mask.
REQ-019 Source i SHALL be eligible when pending[i]=1 and mask[i]=1.
REQ-020 Priority SHALL be fixed: source 0 highest, then 1, then 2.
REQ-021 The FSM SHALL have three states: IDLE, REQ and SERVICE.
REQ-022 In IDLE, if any source is eligible, the FSM SHALL go to REQ at the next edge and register exp_cause and exp_vector.
REQ-023 exp_vector SHALL equal VEC_BASE + cause*VEC_STRIDE, with 32-bit wrap.
REQ-024 has_exp SHALL be 1 exactly in REQ; exp_cause and exp_vector SHALL stay stable throughout REQ.
REQ-025 Latency: an edge sampled at edge k SHALL give has_exp=1 after edge k+1, when eligible and the FSM is IDLE.
REQ-026 exp_ack in REQ SHALL clear pending[exp_cause] and move the FSM to SERVICE; exp_ack outside REQ SHALL be ignored.
REQ-027 A mask change or a higher-priority edge during REQ SHALL NOT change or withdraw the outstanding request.
REQ-028 SERVICE SHALL block new requests (no nesting); in_service=1 in SERVICE only.
REQ-029 eret in SERVICE SHALL return the FSM to IDLE; eret in IDLE or REQ SHALL be ignored.
REQ-030 If an edge on the granted source coincides with exp_ack, the edge SHALL win and pending stays 1.
REQ-031 eret plus an eligible pending source in the same cycle SHALL give IDLE, then REQ one edge later; no cycle skipping.
REQ-032 mask_we SHALL update mask at the edge; the new value SHALL affect eligibility from the next cycle.

Reset
REQ-033 On rst=1 at an edge, the block SHALL set: state=IDLE, pending=0, prev=0, mask=3'b111, exp_cause=0, exp_vector=VEC_BASE, counters=0.
REQ-034 Reset SHALL override all other inputs, including mid-REQ and mid-SERVICE.
REQ-035 A source held high through reset SHALL register one edge in the first cycle after reset.

Configuration
REQ-036 With macro EXP_CNT_EN defined, cnt[i] SHALL increment on each exp_ack grant of source i and saturate at 16'hFFFF.
REQ-037 Without EXP_CNT_EN, cnt0..cnt2 SHALL be constant 0 and no counter flops SHALL exist.

Structure
REQ-038 Package exp_pkg SHALL hold the state encoding (IDLE/REQ/SERVICE), the 2-bit cause type, the NUM_SRC=3 constant and the CNT_W=16 constant.
REQ-039 One sub-module, exp_edge_pending, SHALL implement the per-source prev register, edge detect and pending set/clear; it is instantiated 3 times.

Verification
REQ-040 Scenario: reset, then a pulse on exp_src=3'b100 -> has_exp=1 two edges later, exp_cause=2, exp_vector=32'h0000_0820.
REQ-041 Scenario: exp_src goes 3'b000 -> 3'b110 in one cycle -> cause 1 granted; after ack+eret, cause 2 granted with exp_vector=32'h0000_0820.
REQ-042 Scenario: mask=3'b110, edge on source 0 -> no has_exp, pending=3'b001; write mask=3'b111 -> has_exp one edge later with cause 0.
REQ-043 Scenario: in SERVICE, edge on source 0 -> in_service stays 1, has_exp=0; eret -> IDLE, then has_exp with cause 0.
REQ-044 Scenario: rst asserted in REQ -> next cycle has_exp=0, pending=0, mask=3'b111.
REQ-045 Scenario (EXP_CNT_EN): 3 grants of source 1 -> cnt1=3; preload near 16'hFFFF -> cnt1 holds at 16'hFFFF.

Source files
------------

// File: rtl/exp_pkg.sv
// exp_pkg: shared types and constants for the exception arbiter.
//   state_e      - arbiter FSM states (IDLE / REQ / SERVICE)
//   cause_t      - 2-bit granted source index
//   NUM_SRC      - number of exception sources (3)
//   CNT_W        - width of the per-source grant counters (16)
//   cause_vector - handler address for a cause: base + cause*stride, 32-bit wrap
package exp_pkg;

  localparam int unsigned NUM_SRC = 3;
  localparam int unsigned CNT_W   = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_e;

  typedef logic [1:0] cause_t;

  function automatic logic [31:0] cause_vector(input logic [31:0] base,
                                               input logic [31:0] stride,
                                               input cause_t      cause);
    return base + ({30'd0, cause} * stride);
  endfunction

endpackage

// File: rtl/exp_edge_pending.sv
// exp_edge_pending: one exception source lane.
//   Registers the raw source, detects its rising edge and keeps a sticky
//   pending bit. A rising edge sets pending; clr drops it. When an edge and
//   clr land in the same cycle the edge wins, so a fresh exception is never
//   lost behind the one being acknowledged.
// Ports:
//   clk     - clock, rising edge
//   rst     - synchronous active-high reset (clears prev and pending)
//   src     - raw exception source
//   clr     - acknowledge of this source's outstanding request
//   pending - sticky pending flag
module exp_edge_pending (
  input  logic clk,
  input  logic rst,
  input  logic src,
  input  logic clr,
  output logic pending
);

  logic prev_q, prev_d;
  logic pend_q, pend_d;
  logic rise;

  always_comb begin
    rise   = src & ~prev_q;
    prev_d = src;
    pend_d = rise | (pend_q & ~clr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      prev_q <= prev_d;
      pend_q <= pend_d;
    end
  end

  assign pending = pend_q;

endmodule

// File: rtl/exp_arbiter.sv
// exp_arbiter: fixed-priority exception arbiter with vectored handler addresses.
//   Three edge-triggered sources latch into pending bits; the lowest-index
//   source that is pending and unmasked is granted. A grant is held on
//   has_exp/exp_cause/exp_vector until exp_ack, after which the arbiter stays
//   in SERVICE (no nesting) until eret.
// Parameters:
//   VEC_BASE   - exception vector base address
//   VEC_STRIDE - address distance between per-cause vectors
// Ports:
//   clk, rst              - clock and synchronous active-high reset
//   exp_src[2:0]          - raw exception sources (bit 0 = highest priority)
//   mask_we, mask_din     - mask register write strobe / value (1 = enabled)
//   exp_ack               - PC logic took the outstanding exception
//   eret                  - return from handler
//   has_exp               - exception request (high only in REQ)
//   exp_cause, exp_vector - granted source and its handler address
//   in_service            - handler running (high only in SERVICE)
//   pending, mask         - visible pending bits and mask register
//   cnt0..cnt2            - per-source grant counts
// Configuration:
//   EXP_CNT_EN - when defined, saturating 16-bit grant counters are built;
//                otherwise cnt0..cnt2 are tied to zero.
module exp_arbiter
  import exp_pkg::*;
#(
  parameter logic [31:0] VEC_BASE   = 32'h0000_0800,
  parameter logic [31:0] VEC_STRIDE = 32'h0000_0010
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] exp_src,
  input  logic               mask_we,
  input  logic [NUM_SRC-1:0] mask_din,
  input  logic               exp_ack,
  input  logic               eret,
  output logic               has_exp,
  output logic [1:0]         exp_cause,
  output logic [31:0]        exp_vector,
  output logic               in_service,
  output logic [NUM_SRC-1:0] pending,
  output logic [NUM_SRC-1:0] mask,
  output logic [CNT_W-1:0]   cnt0,
  output logic [CNT_W-1:0]   cnt1,
  output logic [CNT_W-1:0]   cnt2
);

  state_e             state_q, state_d;
  cause_t             cause_q, cause_d;
  logic [31:0]        vector_q, vector_d;
  logic [NUM_SRC-1:0] mask_q, mask_d;

  logic [NUM_SRC-1:0] pend;
  logic [NUM_SRC-1:0] clr;
  logic [NUM_SRC-1:0] eligible;
  logic               any_eligible;
  logic               grant_ack;
  cause_t             sel_cause;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    exp_edge_pending u_edge (
      .clk     (clk),
      .rst     (rst),
      .src     (exp_src[g]),
      .clr     (clr[g]),
      .pending (pend[g])
    );
  end

  // Eligibility uses the registered mask, so a mask write only takes effect
  // from the cycle after the write edge.
  always_comb begin
    eligible     = pend & mask_q;
    any_eligible = |eligible;
    sel_cause    = '0;
    for (int unsigned i = NUM_SRC; i > 0; i--) begin
      if (eligible[i-1]) sel_cause = cause_t'(i - 1);
    end
  end

  // Acknowledge only counts while a request is outstanding; it clears the
  // pending bit of the cause that was granted, not the current winner.
  always_comb begin
    grant_ack = (state_q == ST_REQ) && exp_ack;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      clr[i] = grant_ack && (cause_q == cause_t'(i));
    end
  end

  always_comb begin
    state_d  = state_q;
    cause_d  = cause_q;
    vector_d = vector_q;
    mask_d   = mask_we ? mask_din : mask_q;
    unique case (state_q)
      ST_IDLE: begin
        if (any_eligible) begin
          state_d  = ST_REQ;
          cause_d  = sel_cause;
          vector_d = cause_vector(VEC_BASE, VEC_STRIDE, sel_cause);
        end
      end
      ST_REQ: begin
        if (exp_ack) state_d = ST_SERVICE;
      end
      ST_SERVICE: begin
        if (eret) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cause_q  <= '0;
      vector_q <= VEC_BASE;
      mask_q   <= '1;
    end else begin
      state_q  <= state_d;
      cause_q  <= cause_d;
      vector_q <= vector_d;
      mask_q   <= mask_d;
    end
  end

  assign has_exp    = (state_q == ST_REQ);
  assign in_service = (state_q == ST_SERVICE);
  assign exp_cause  = cause_q;
  assign exp_vector = vector_q;
  assign pending    = pend;
  assign mask       = mask_q;

`ifdef EXP_CNT_EN
  logic [CNT_W-1:0] cnt_q [NUM_SRC];
  logic [CNT_W-1:0] cnt_d [NUM_SRC];

  always_comb begin
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      cnt_d[i] = cnt_q[i];
      if (clr[i] && (cnt_q[i] != '1)) cnt_d[i] = cnt_q[i] + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_SRC; i++) cnt_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_SRC; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign cnt0 = cnt_q[0];
  assign cnt1 = cnt_q[1];
  assign cnt2 = cnt_q[2];
`else
  assign cnt0 = '0;
  assign cnt1 = '0;
  assign cnt2 = '0;
`endif

endmodule
